// File: rtl/lsu_sized_if.sv
// Load/store bus bundle for lsu_sized: core-side request/response plus the
// data cache port. The slave modport is the LSU's view; master is the
// core/cache environment driving it.
interface lsu_sized_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  localparam int BE_W = DATA_WIDTH / 8;

  // core side
  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic                  mem_valid;
  logic                  mem_err;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // cache side
  logic                  data_req;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic                  data_we;
  logic [BE_W-1:0]       byte_enable;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] rdata;

  modport slave (
    input  mem_req, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata,
    output mem_ready, mem_valid, mem_err, mem_rdata,
    output data_req, data_addr, data_we, byte_enable, wdata,
    input  data_valid, rdata
  );

  modport master (
    output mem_req, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata,
    input  mem_ready, mem_valid, mem_err, mem_rdata,
    input  data_req, data_addr, data_we, byte_enable, wdata,
    output data_valid, rdata
  );
endinterface

// File: rtl/lsu_sized.sv
// lsu_sized: single-outstanding load/store unit. Aligns byte/half/word/double
// accesses onto the cache bus, holds the request until acknowledged and
// returns a sign/zero-extended load result. Misaligned or illegal-size
// accesses complete with mem_err and never reach the cache.
// Optional: define LSU_TIMEOUT_EN to abort a cache wait after TIMEOUT_CYCLES.
module lsu_sized #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BYTE_EN_WIDTH  = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  lsu_sized_if.slave  bus
);
  localparam int OFF_W = $clog2(BYTE_EN_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTE_EN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                   state_q, state_d;
  logic                     we_q, we_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [OFF_W-1:0]         off_q, off_d;
  logic                     mem_ready_q, mem_ready_d;
  logic                     mem_valid_q, mem_valid_d;
  logic                     mem_err_q, mem_err_d;
  logic [DATA_WIDTH-1:0]    mem_rdata_q, mem_rdata_d;
  logic                     data_req_q, data_req_d;
  logic [ADDR_WIDTH-1:0]    data_addr_q, data_addr_d;
  logic                     data_we_q, data_we_d;
  logic [BYTE_EN_WIDTH-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Decode of the incoming request: lane offset, legality, enables, store data
  logic [OFF_W-1:0]         off_in;
  logic                     bad_in;
  logic [BYTE_EN_WIDTH-1:0] be_in;
  logic [DATA_WIDTH-1:0]    wd_in;

  always_comb begin
    off_in = bus.mem_addr[OFF_W-1:0];
    bad_in = 1'b0;
    be_in  = '1;
    wd_in  = bus.mem_wdata;
    case (bus.mem_size)
      2'd0: begin
        be_in = BYTE_EN_WIDTH'(1) << off_in;
        wd_in = {(DATA_WIDTH/8){bus.mem_wdata[7:0]}};
      end
      2'd1: begin
        bad_in = off_in[0];
        be_in  = BYTE_EN_WIDTH'(2'b11) << off_in;
        wd_in  = {(DATA_WIDTH/16){bus.mem_wdata[15:0]}};
      end
      2'd2: begin
        bad_in = (off_in[1:0] != 2'b00);
        be_in  = BYTE_EN_WIDTH'(4'b1111) << off_in;
        wd_in  = {(DATA_WIDTH/32){bus.mem_wdata[31:0]}};
      end
      default: begin
        // doubleword only exists on a 64-bit bus and must be fully aligned
        bad_in = (DATA_WIDTH != 64) || (off_in != '0);
      end
    endcase
  end

  // Load result: shift the addressed lane down, mask to size, extend
  logic [DATA_WIDTH-1:0] shifted, size_mask, load_res;
  logic                  sign_bit;

  always_comb begin
    shifted = bus.rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    begin size_mask = DATA_WIDTH'(8'hFF);          sign_bit = shifted[7];  end
      2'd1:    begin size_mask = DATA_WIDTH'(16'hFFFF);       sign_bit = shifted[15]; end
      2'd2:    begin size_mask = DATA_WIDTH'(32'hFFFF_FFFF);  sign_bit = shifted[31]; end
      default: begin size_mask = '1;                          sign_bit = 1'b0;        end
    endcase
    load_res = (shifted & size_mask) | ((!uns_q && sign_bit) ? ~size_mask : '0);
  end

  // Next-state and next-output logic for the IDLE/REQ/RESP sequencer
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    mem_ready_d = mem_ready_q;
    mem_valid_d = 1'b0;
    mem_err_d   = mem_err_q;
    mem_rdata_d = mem_rdata_q;
    data_req_d  = data_req_q;
    data_addr_d = data_addr_q;
    data_we_d   = data_we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        mem_ready_d = 1'b1;
        if (bus.mem_req) begin
          we_d        = bus.mem_we;
          size_d      = bus.mem_size;
          uns_d       = bus.mem_unsigned;
          off_d       = off_in;
          mem_ready_d = 1'b0;
          if (bad_in) begin
            // error completes straight away; cache outputs untouched
            state_d     = RESP;
            mem_valid_d = 1'b1;
            mem_err_d   = 1'b1;
          end else begin
            state_d     = REQ;
            data_req_d  = 1'b1;
            data_addr_d = bus.mem_addr & ~LANE_MASK;
            data_we_d   = bus.mem_we;
            be_d        = be_in;
            wdata_d     = wd_in;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      REQ: begin
        if (bus.data_valid) begin
          state_d     = RESP;
          data_req_d  = 1'b0;
          mem_valid_d = 1'b1;
          mem_err_d   = 1'b0;
          if (!we_q) mem_rdata_d = load_res;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          data_req_d  = 1'b0;
          mem_valid_d = 1'b1;
          mem_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d     = IDLE;
        mem_ready_d = 1'b1;
        mem_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      mem_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= '0;
      data_req_q  <= 1'b0;
      data_addr_q <= '0;
      data_we_q   <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      mem_ready_q <= mem_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_err_q   <= mem_err_d;
      mem_rdata_q <= mem_rdata_d;
      data_req_q  <= data_req_d;
      data_addr_q <= data_addr_d;
      data_we_q   <= data_we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.mem_ready   = mem_ready_q;
  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_err     = mem_err_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.data_req    = data_req_q;
  assign bus.data_addr   = data_addr_q;
  assign bus.data_we     = data_we_q;
  assign bus.byte_enable = be_q;
  assign bus.wdata       = wdata_q;
endmodule
